// File: rtl/jet_tag_stream_adapter.sv
// -----------------------------------------------------------------------------
// jet_tag_stream_adapter
//
// Stream-side front/back end for the jet-tagging MLP top. Collects a serial
// stream of fixed-point features into an INPUT_SIZE-element vector, launches
// the network with a one-cycle start pulse, waits for its result, captures the
// OUTPUT_SIZE scores and streams them back out serially with the argmax class
// attached. One frame is in flight at a time; data passes through bit-exact.
//
// Handshake rule (both stream ports): a word transfers on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// unchanged until the transfer; valid never depends combinationally on ready.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   s_valid/s_ready     feature stream handshake
//   s_data, s_last      feature word, end-of-frame marker
//   net_input_ready     one-cycle start pulse to the network (FIRE)
//   net_input_data      assembled feature vector, stable FIRE..WAIT exit
//   net_output_ready    network result valid (only honoured in WAIT)
//   net_output_data     network scores
//   m_valid/m_ready     result stream handshake
//   m_data, m_last      current score word, last-score marker
//   m_class             argmax index of the captured scores (ties -> lowest)
//   busy                high in FIRE, WAIT, DRAIN
//   err_frame           one-cycle pulse after a framing error
//   err_timeout         one-cycle pulse on the last WAIT cycle of a timeout
//   dbg_state           current FSM state (FILL=0, FIRE=1, WAIT=2, DRAIN=3)
//
// Every output is forced to 0 while reset is high.
// -----------------------------------------------------------------------------
module jet_tag_stream_adapter #(
  parameter int WIDTH         = 16,
  parameter int NFRAC         = 10,
  parameter int INPUT_SIZE    = 16,
  parameter int OUTPUT_SIZE   = 5,
  parameter int TIMEOUT       = 4096,
  parameter int CAPTURE_DELAY = 0,
  localparam int CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             net_input_ready,
  output logic [WIDTH-1:0] net_input_data [INPUT_SIZE],
  input  logic             net_output_ready,
  input  logic [WIDTH-1:0] net_output_data [OUTPUT_SIZE],
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CW-1:0]    m_class,
  output logic             busy,
  output logic             err_frame,
  output logic             err_timeout,
  output logic [1:0]       dbg_state
);

  localparam int IW    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int KW    = CW;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DLY_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

  // Scores are treated as opaque words here; the fractional point only
  // matters to whoever interprets them, but it must fit inside a word.
  if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("NFRAC must lie in [0, WIDTH-1]");
  end

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FIRE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] cnt;
  logic [DLY_W-1:0] dly;
  logic             seen;
  logic [WIDTH-1:0] feat [INPUT_SIZE];
  logic [WIDTH-1:0] res  [OUTPUT_SIZE];
  logic [CW-1:0]    cls, cls_nxt;
  logic             err_frame_q;

  logic accept, at_end, frame_bad, frame_done;
  logic capture, timeout, last_word;

  // FILL always has s_ready high, so a valid word in FILL is accepted.
  assign accept     = (state == FILL) && s_valid;
  assign at_end     = (idx == IW'(INPUT_SIZE - 1));
  // s_last must coincide exactly with the final slot; anything else drops
  // the word and restarts the frame.
  assign frame_bad  = accept && (s_last != at_end);
  assign frame_done = accept && s_last && at_end;
  assign last_word  = (k == KW'(OUTPUT_SIZE - 1));

  // With no delay the capture edge is the one that first samples
  // net_output_ready; otherwise count further cycles after it was seen.
  assign capture = (state == WAIT) &&
                   ((CAPTURE_DELAY == 0) ? net_output_ready
                                         : (seen && (dly == DLY_W'(CAPTURE_DELAY - 1))));

  // A result that shows up on the final WAIT cycle (or is already pending
  // its capture delay) wins over the timeout.
  assign timeout = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1)) &&
                   !seen && !net_output_ready;

  // Argmax over signed scores; strict '>' keeps the lowest index on ties.
  always_comb begin
    logic signed [WIDTH-1:0] best_v;
    cls_nxt = '0;
    best_v  = $signed(net_output_data[0]);
    for (int i = 1; i < OUTPUT_SIZE; i++) begin
      if ($signed(net_output_data[i]) > best_v) begin
        best_v  = $signed(net_output_data[i]);
        cls_nxt = CW'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (frame_done) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = DRAIN;
               else if (timeout) state_nxt = FILL;
      DRAIN:   if (m_ready && last_word) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      k           <= '0;
      cnt         <= '0;
      dly         <= '0;
      seen        <= 1'b0;
      cls         <= '0;
      err_frame_q <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++)  feat[i] <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) res[i]  <= '0;
    end else begin
      state       <= state_nxt;
      err_frame_q <= frame_bad;

      // Feature registers are written only here, so net_input_data holds
      // still for the whole FIRE/WAIT window.
      if (accept) begin
        if (frame_bad) begin
          idx <= '0;
        end else begin
          feat[idx] <= s_data;
          idx       <= at_end ? '0 : idx + IW'(1);
        end
      end

      if (state == FIRE) begin
        cnt  <= '0;
        dly  <= '0;
        seen <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
        if (!seen && net_output_ready) begin
          seen <= 1'b1;
          dly  <= '0;
        end else if (seen) begin
          dly <= dly + DLY_W'(1);
        end
      end

      if (capture) begin
        for (int i = 0; i < OUTPUT_SIZE; i++) res[i] <= net_output_data[i];
        cls <= cls_nxt;
      end

      if (state == DRAIN && m_ready) begin
        k <= last_word ? '0 : k + KW'(1);
      end
    end
  end

  always_comb begin
    s_ready         = 1'b0;
    net_input_ready = 1'b0;
    m_valid         = 1'b0;
    m_data          = '0;
    m_last          = 1'b0;
    m_class         = '0;
    busy            = 1'b0;
    err_frame       = 1'b0;
    err_timeout     = 1'b0;
    dbg_state       = 2'd0;
    for (int i = 0; i < INPUT_SIZE; i++) net_input_data[i] = '0;
    if (!reset) begin
      s_ready         = (state == FILL);
      net_input_ready = (state == FIRE);
      m_valid         = (state == DRAIN);
      m_data          = (state == DRAIN) ? res[k] : '0;
      m_last          = (state == DRAIN) && last_word;
      m_class         = cls;
      busy            = (state != FILL);
      err_frame       = err_frame_q;
      err_timeout     = timeout;
      dbg_state       = state;
      for (int i = 0; i < INPUT_SIZE; i++) net_input_data[i] = feat[i];
    end
  end

endmodule

// File: tb/tb_jet_tag_stream_adapter.sv
module tb_jet_tag_stream_adapter;

  localparam int W   = 16;
  localparam int IN  = 16;
  localparam int OUT = 5;
  localparam int TO  = 4096;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          net_input_ready;
  logic [W-1:0]  net_input_data [IN];
  logic          net_output_ready;
  logic [W-1:0]  net_output_data [OUT];
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [2:0]    m_class;
  logic          busy;
  logic          err_frame;
  logic          err_timeout;
  logic [1:0]    dbg_state;

  jet_tag_stream_adapter #(
    .WIDTH(W), .NFRAC(10), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT),
    .TIMEOUT(TO), .CAPTURE_DELAY(0)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .net_input_ready(net_input_ready), .net_input_data(net_input_data),
    .net_output_ready(net_output_ready), .net_output_data(net_output_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_class(m_class), .busy(busy), .err_frame(err_frame),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  // entry = {class[2:0], last, data[15:0]}
  logic [19:0] exp_q[$];
  logic [W-1:0] exp_feat [IN];
  logic [W-1:0] scores [OUT];
  int fire_cnt = 0;
  int ef_cnt   = 0;
  int et_cnt   = 0;
  int fire_cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: hold low

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_class();
    int best = 0;
    for (int i = 1; i < OUT; i++)
      if ($signed(scores[i]) > $signed(scores[best])) best = i;
    return 3'(best);
  endfunction

  // Output monitor: every cycle with m_valid, the word on the bus must be
  // the head of the expected queue; it is retired when m_ready is also high.
  always @(negedge clk) begin
    if (net_input_ready) fire_cnt++;
    if (err_frame)       ef_cnt++;
    if (err_timeout)     et_cnt++;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("m_valid_unexpected", 32'(m_valid), 32'd0);
      end else begin
        check("m_data",  32'(m_data),  32'(exp_q[0][15:0]));
        check("m_last",  32'(m_last),  32'(exp_q[0][16]));
        check("m_class", 32'(m_class), 32'(exp_q[0][19:17]));
        check("s_ready_drain", 32'(s_ready), 32'd0);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_word(input logic [W-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
  endtask

  // Sends a full clean frame; returns one cycle into WAIT.
  task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] step);
    int f0 = fire_cnt;
    for (int i = 0; i < IN; i++) begin
      exp_feat[i] = base + W'(i) * step;
      send_word(exp_feat[i], (i == IN - 1));
    end
    // cycle right after the last accepted word must be FIRE
    fire_cyc = cyc;
    check("fire_pulse", 32'(net_input_ready), 32'd1);
    check("busy_fire", 32'(busy), 32'd1);
    for (int i = 0; i < IN; i++)
      check($sformatf("feat[%0d]", i), 32'(net_input_data[i]), 32'(exp_feat[i]));
    @(negedge clk);
    check("fire_once", 32'(fire_cnt), 32'(f0 + 1));
    check("fire_low_in_wait", 32'(net_input_ready), 32'd0);
    check("state_wait", 32'(dbg_state), 32'(ST_WAIT));
  endtask

  // Called one cycle into WAIT; result shows up wait_cycles after FIRE.
  task automatic respond(input int wait_cycles);
    logic [2:0] c;
    repeat (wait_cycles - 1) @(negedge clk);
    c = model_class();
    for (int i = 0; i < IN; i++)
      check("feat_stable", 32'(net_input_data[i]), 32'(exp_feat[i]));
    for (int i = 0; i < OUT; i++) begin
      logic lst = (i == OUT - 1);
      net_output_data[i] = scores[i];
      exp_q.push_back({c, lst, scores[i]});
    end
    net_output_ready = 1'b1;
    @(negedge clk);
    net_output_ready = 1'b0;
    check("m_valid_latency", 32'(m_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("s_ready_after_drain", 32'(s_ready), 32'd1);
    check("m_valid_after_drain", 32'(m_valid), 32'd0);
    check("busy_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string where);
    check({where, "_s_ready"}, 32'(s_ready), 32'd0);
    check({where, "_fire"}, 32'(net_input_ready), 32'd0);
    check({where, "_m_valid"}, 32'(m_valid), 32'd0);
    check({where, "_m_data"}, 32'(m_data), 32'd0);
    check({where, "_m_class"}, 32'(m_class), 32'd0);
    check({where, "_busy"}, 32'(busy), 32'd0);
    check({where, "_err"}, 32'({err_frame, err_timeout}), 32'd0);
    check({where, "_state"}, 32'(dbg_state), 32'(ST_FILL));
    check({where, "_feat0"}, 32'(net_input_data[0]), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_post_reset", 32'(s_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    net_output_ready = 1'b0;
    for (int i = 0; i < OUT; i++) net_output_data[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("init");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_rise", 32'(s_ready), 32'd1);

    // 1) ramp frame, result 30 cycles after FIRE, tie between 1 and 3
    send_frame(16'h0000, 16'h0040);
    scores[0] = 16'h0100; scores[1] = 16'h0300; scores[2] = 16'h0080;
    scores[3] = 16'h0300; scores[4] = 16'h0010;
    check("model_tie_low", 32'(model_class()), 32'd1);
    respond(30);
    wait_drain();

    // 2) s_last on word 7 -> framing error, no FIRE
    for (int i = 0; i < 8; i++) send_word(16'h1000 + 16'(i), (i == 7));
    check("err_frame_pulse", 32'(err_frame), 32'd1);
    check("no_fire_on_err", 32'(net_input_ready), 32'd0);
    check("s_ready_after_err", 32'(s_ready), 32'd1);
    @(negedge clk);
    check("err_frame_one_cycle", 32'(err_frame), 32'd0);

    // 3) clean frame with fresh data, negative scores, m_ready toggling
    send_frame(16'h2000, 16'h0003);
    scores[0] = 16'hfffb; scores[1] = 16'hffff; scores[2] = 16'hfe00;
    scores[3] = 16'hffff; scores[4] = 16'h8001;
    ready_mode = 1;
    respond(5);
    wait_drain();
    ready_mode = 0;

    // 4) no result -> timeout exactly TO cycles after FIRE
    send_frame(16'h0f00, 16'hff11);
    begin
      int n = 0;
      while (!err_timeout && n < TO + 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("err_timeout_pulse", 32'(err_timeout), 32'd1);
    check("timeout_cycle", 32'(cyc - fire_cyc), 32'(TO));
    @(negedge clk);
    check("timeout_one_cycle", 32'(err_timeout), 32'd0);
    check("timeout_state", 32'(dbg_state), 32'(ST_FILL));
    check("timeout_s_ready", 32'(s_ready), 32'd1);

    // 5) reset while in WAIT
    send_frame(16'h0123, 16'h0101);
    repeat (3) @(negedge clk);
    pulse_reset();

    // 6) reset while in DRAIN with the consumer stalled
    send_frame(16'h4444, 16'h0010);
    scores[0] = 16'h0001; scores[1] = 16'h0002; scores[2] = 16'h0003;
    scores[3] = 16'h0004; scores[4] = 16'h7fff;
    ready_mode = 2;
    respond(8);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("reset_drain");
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("s_ready_post_drain_reset", 32'(s_ready), 32'd1);

    // 7) stray net_output_ready in FILL is ignored
    net_output_ready = 1'b1;
    repeat (2) @(negedge clk);
    net_output_ready = 1'b0;
    check("stray_ready_busy", 32'(busy), 32'd0);
    check("stray_ready_state", 32'(dbg_state), 32'(ST_FILL));

    // 8) normal frame after the resets, max on the last score
    send_frame(16'(16'h7000 + 16'($urandom_range(0, 255))), 16'(16'h0100 + 16'($urandom_range(0, 15))));
    for (int i = 0; i < OUT - 1; i++) scores[i] = 16'($urandom_range(0, 16'h3fff));
    scores[OUT-1] = 16'h7fff;
    respond(10);
    wait_drain();

    check("err_frame_total", 32'(ef_cnt), 32'd1);
    check("err_timeout_total", 32'(et_cnt), 32'd1);
    check("fire_total", 32'(fire_cnt), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
